// File: rtl/rpn_lan_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the Network Bridge LAN AXI-Stream input.
// A grant lasts from the first beat to the accepted tlast beat; the output beat is registered.
module rpn_lan_tx_arbiter #(
    parameter int NUM_REQ              = 3,
    parameter int AXIS_DATA_WIDTH      = 512,
    parameter int AXIS_KEEP_WIDTH      = 64,
    parameter int AXIS_LAN_TDEST_WIDTH = 16,
    parameter int AXIS_LAN_TUSER_WIDTH = 16,
    parameter int HOLD_TIMEOUT         = 1024
) (
    input  logic                                    i_clk,
    input  logic                                    i_ap_rst,
    input  logic [NUM_REQ-1:0]                      req_tvalid,
    output logic [NUM_REQ-1:0]                      req_tready,
    input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]      req_tdata,
    input  logic [NUM_REQ*AXIS_KEEP_WIDTH-1:0]      req_tkeep,
    input  logic [NUM_REQ*AXIS_LAN_TDEST_WIDTH-1:0] req_tid,
    input  logic [NUM_REQ*AXIS_LAN_TDEST_WIDTH-1:0] req_tdest,
    input  logic [NUM_REQ*AXIS_LAN_TUSER_WIDTH-1:0] req_tuser,
    input  logic [NUM_REQ-1:0]                      req_tlast,
    output logic                                    to_nb_LAN_tvalid,
    input  logic                                    to_nb_LAN_tready,
    output logic [AXIS_DATA_WIDTH-1:0]              to_nb_LAN_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]              to_nb_LAN_tkeep,
    output logic [AXIS_LAN_TDEST_WIDTH-1:0]         to_nb_LAN_tid,
    output logic [AXIS_LAN_TDEST_WIDTH-1:0]         to_nb_LAN_tdest,
    output logic [AXIS_LAN_TUSER_WIDTH-1:0]         to_nb_LAN_tuser,
    output logic                                    to_nb_LAN_tlast,
    output logic [NUM_REQ-1:0]                      o_grant,
    output logic                                    o_hold_timeout
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [IDX_W:0] NREQ_C = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic                            timeout_q, timeout_d;
    logic                            out_valid_q, out_valid_d;
    logic [AXIS_DATA_WIDTH-1:0]      data_q;
    logic [AXIS_KEEP_WIDTH-1:0]      keep_q;
    logic [AXIS_LAN_TDEST_WIDTH-1:0] tid_q;
    logic [AXIS_LAN_TDEST_WIDTH-1:0] dest_q;
    logic [AXIS_LAN_TUSER_WIDTH-1:0] user_q;
    logic                            last_beat_q;

    logic             any_vld;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic             ready_ok;
    logic             gnt_vld;
    logic             accept;
    logic             pkt_end;
    logic             wd_fire;

    // Round-robin search starting just above the previous winner, with wrap.
    always_comb begin
        pick    = last_q;
        any_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IDX_W + 1)'(k);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (!any_vld && req_tvalid[cand[IDX_W-1:0]]) begin
                any_vld = 1'b1;
                pick    = cand[IDX_W-1:0];
            end
        end
    end

    // While LOCKED, last_q is the index of the granted requester.
    assign ready_ok = !out_valid_q || to_nb_LAN_tready;
    assign gnt_vld  = req_tvalid[last_q];
    assign accept   = (state_q == LOCKED) && gnt_vld && ready_ok;
    assign pkt_end  = accept && req_tlast[last_q];
    assign wd_fire  = (state_q == LOCKED) && !gnt_vld && (wd_q == WD_W'(HOLD_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:    if (any_vld) state_d = LOCKED;
            LOCKED: if (pkt_end || wd_fire) state_d = ARB;
        endcase
    end

    always_comb begin
        req_tready = '0;
        if (state_q == LOCKED) begin
            req_tready = grant_q & {NUM_REQ{ready_ok}};
        end
    end

    always_comb begin
        last_d    = last_q;
        grant_d   = grant_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_q == ARB) begin
            wd_d    = '0;
            grant_d = '0;
            if (any_vld) begin
                last_d  = pick;
                grant_d = NUM_REQ'(1) << pick;
            end
        end else begin
            if (accept) begin
                wd_d = '0;
            end else if (!gnt_vld) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (pkt_end) begin
                grant_d = '0;
            end
            // A stalled packet is abandoned, never completed with a made-up beat.
            if (wd_fire) begin
                grant_d   = '0;
                wd_d      = '0;
                timeout_d = 1'b1;
            end
        end
    end

    assign out_valid_d = accept || (out_valid_q && !to_nb_LAN_tready);

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            last_q      <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            tid_q       <= '0;
            dest_q      <= '0;
            user_q      <= '0;
            last_beat_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            grant_q     <= grant_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                data_q      <= req_tdata[last_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                keep_q      <= req_tkeep[last_q*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
                tid_q       <= req_tid[last_q*AXIS_LAN_TDEST_WIDTH +: AXIS_LAN_TDEST_WIDTH];
                dest_q      <= req_tdest[last_q*AXIS_LAN_TDEST_WIDTH +: AXIS_LAN_TDEST_WIDTH];
                user_q      <= req_tuser[last_q*AXIS_LAN_TUSER_WIDTH +: AXIS_LAN_TUSER_WIDTH];
                last_beat_q <= req_tlast[last_q];
            end
        end
    end

    assign to_nb_LAN_tvalid = out_valid_q;
    assign to_nb_LAN_tdata  = data_q;
    assign to_nb_LAN_tkeep  = keep_q;
    assign to_nb_LAN_tid    = tid_q;
    assign to_nb_LAN_tdest  = dest_q;
    assign to_nb_LAN_tuser  = user_q;
    assign to_nb_LAN_tlast  = last_beat_q;
    assign o_grant          = grant_q;
    assign o_hold_timeout   = timeout_q;

endmodule

// File: tb/tb_rpn_lan_tx_arbiter.sv
// Bench for rpn_lan_tx_arbiter: directed scenarios, then randomized traffic scored
// per requester at packet level (order within a source, no interleaving).
`timescale 1ns/1ps
module tb_rpn_lan_tx_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int TW = 8;
    localparam int UW = 8;
    localparam int HT = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [TW-1:0] id;
        logic [TW-1:0] dest;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]    req_tvalid, req_tready, req_tlast, o_grant;
    logic [N*DW-1:0] req_tdata;
    logic [N*KW-1:0] req_tkeep;
    logic [N*TW-1:0] req_tid, req_tdest;
    logic [N*UW-1:0] req_tuser;
    logic            nb_tvalid, nb_tready, nb_tlast, hold_to;
    logic [DW-1:0]   nb_tdata;
    logic [KW-1:0]   nb_tkeep;
    logic [TW-1:0]   nb_tid, nb_tdest;
    logic [UW-1:0]   nb_tuser;

    rpn_lan_tx_arbiter #(
        .NUM_REQ(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
        .AXIS_LAN_TDEST_WIDTH(TW), .AXIS_LAN_TUSER_WIDTH(UW), .HOLD_TIMEOUT(HT)
    ) dut (
        .i_clk(clk), .i_ap_rst(rst),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
        .req_tkeep(req_tkeep), .req_tid(req_tid), .req_tdest(req_tdest),
        .req_tuser(req_tuser), .req_tlast(req_tlast),
        .to_nb_LAN_tvalid(nb_tvalid), .to_nb_LAN_tready(nb_tready),
        .to_nb_LAN_tdata(nb_tdata), .to_nb_LAN_tkeep(nb_tkeep), .to_nb_LAN_tid(nb_tid),
        .to_nb_LAN_tdest(nb_tdest), .to_nb_LAN_tuser(nb_tuser), .to_nb_LAN_tlast(nb_tlast),
        .o_grant(o_grant), .o_hold_timeout(hold_to)
    );

    always #5 clk = ~clk;

    beat_t    src_q[N][$];
    beat_t    exp_q[N][$];
    logic [N-1:0] hold;
    int       hold_cnt[N];
    int       cur_src;
    int       pkt_order[$];
    int       pkt_cyc[$];
    int       beat_tid[$];
    int       cyc;
    int       checks;
    int       failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b = '0;
            if (src_q[i].size() > 0) b = src_q[i][0];
            req_tvalid[i]           = (src_q[i].size() > 0) && !hold[i];
            req_tdata[i*DW +: DW]   = b.data;
            req_tkeep[i*KW +: KW]   = b.keep;
            req_tid[i*TW +: TW]     = b.id;
            req_tdest[i*TW +: TW]   = b.dest;
            req_tuser[i*UW +: UW]   = b.user;
            req_tlast[i]            = b.last;
        end
    endtask

    task automatic add_pkt(input int s, input int n, input logic [DW-1:0] base);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.data = base + DW'(b);
            x.keep = KW'($urandom);
            x.id   = TW'(s);
            x.dest = TW'($urandom);
            x.user = UW'($urandom);
            x.last = (b == n - 1);
            src_q[s].push_back(x);
            exp_q[s].push_back(x);
        end
        update_drive();
    endtask

    // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        beat_t ob;
        int t;
        @(negedge clk);
        hs = req_tvalid & req_tready;
        chk("tready_subset_grant", 64'(req_tready & ~o_grant), 64'd0);
        chk("tready_onehot0", 64'($onehot0(req_tready)), 64'd1);
        if (nb_tvalid && nb_tready) begin
            ob = {nb_tdata, nb_tkeep, nb_tid, nb_tdest, nb_tuser, nb_tlast};
            t = int'(nb_tid);
            beat_tid.push_back(t);
            if (cur_src >= 0) chk("no_interleave", 64'(t), 64'(cur_src));
            if (t < N && exp_q[t].size() > 0) begin
                chk("beat", 64'(ob), 64'(exp_q[t][0]));
                void'(exp_q[t].pop_front());
            end else begin
                chk("unexpected_beat_src", 64'(t), 64'(N));
            end
            if (ob.last) begin
                pkt_order.push_back(t);
                pkt_cyc.push_back(cyc);
                cur_src = -1;
            end else begin
                cur_src = t;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                hold_cnt[i] = 0;
            end else if (hold[i]) begin
                hold_cnt[i]++;
            end
        end
        update_drive();
        #1;
    endtask

    task automatic flush_model();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            hold_cnt[i] = 0;
        end
        hold    = '0;
        cur_src = -1;
        update_drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        flush_model();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        checks = 0; failures = 0; cur_src = -1; cyc = 0;
        hold = '0; nb_tready = 1'b1;
        for (int i = 0; i < N; i++) hold_cnt[i] = 0;
        update_drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_tvalid",  64'(nb_tvalid), 64'd0);
        chk("rst_tdata",   64'(nb_tdata), 64'd0);
        chk("rst_fields",  64'({nb_tkeep, nb_tid, nb_tdest, nb_tuser, nb_tlast}), 64'd0);
        chk("rst_tready",  64'(req_tready), 64'd0);
        chk("rst_grant",   64'(o_grant), 64'd0);
        chk("rst_timeout", 64'(hold_to), 64'd0);
        rst = 1'b0;
        tick();

        // Single-beat packet from requester 1.
        add_pkt(1, 1, 32'hA5);
        #1;
        chk("t1_c0_grant", 64'(o_grant), 64'd0);
        tick();
        chk("t1_c1_grant",  64'(o_grant), 64'b010);
        chk("t1_c1_tready", 64'(req_tready), 64'b010);
        chk("t1_c1_tvalid", 64'(nb_tvalid), 64'd0);
        tick();
        chk("t1_c2_tvalid", 64'(nb_tvalid), 64'd1);
        chk("t1_c2_tdata",  64'(nb_tdata), 64'hA5);
        chk("t1_c2_tlast",  64'(nb_tlast), 64'd1);
        chk("t1_c2_grant",  64'(o_grant), 64'd0);
        tick();
        chk("t1_c3_tvalid", 64'(nb_tvalid), 64'd0);
        chk("t1_drained",   64'(exp_q[1].size()), 64'd0);

        // Round-robin fairness with all requesters continuously valid.
        do_reset();
        pkt_order.delete(); pkt_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_pkt(s, 1, DW'(32'h100 * (s + 1) + r));
        #1;
        for (int k = 0; k < 40 && pkt_order.size() < 6; k++) tick();
        chk("t2_pkt_count", 64'(pkt_order.size()), 64'd6);
        for (int p = 0; p < pkt_order.size(); p++)
            chk($sformatf("t2_order%0d", p), 64'(pkt_order[p]), 64'(p % 3));
        for (int p = 1; p < pkt_order.size(); p++)
            chk($sformatf("t2_spacing%0d", p), 64'(pkt_cyc[p] - pkt_cyc[p-1]), 64'd2);

        // Multi-beat packet from requester 2 while requester 0 waits.
        beat_tid.delete();
        add_pkt(2, 4, 32'h2000);
        #1;
        tick();
        chk("t3_grant_c1", 64'(o_grant), 64'b100);
        add_pkt(0, 1, 32'h3000);
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_grant_held", 64'(o_grant), 64'b100);
        end
        for (int k = 0; k < 30 && (exp_q[0].size() + exp_q[2].size()) > 0; k++) tick();
        chk("t3_beat_count", 64'(beat_tid.size()), 64'd5);
        for (int k = 0; k < beat_tid.size(); k++)
            chk($sformatf("t3_src%0d", k), 64'(beat_tid[k]), (k < 4) ? 64'd2 : 64'd0);

        // Downstream backpressure mid-packet.
        beat_tid.delete();
        add_pkt(1, 4, 32'h4000);
        #1;
        tick(); tick(); tick();
        nb_tready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_tvalid", 64'(nb_tvalid), 64'd1);
            chk("t4_hold_tdata",  64'(nb_tdata), 64'h4001);
            chk("t4_hold_tready", 64'(req_tready), 64'd0);
            chk("t4_hold_grant",  64'(o_grant), 64'b010);
            tick();
        end
        nb_tready = 1'b1;
        #1;
        for (int k = 0; k < 30 && exp_q[1].size() > 0; k++) tick();
        chk("t4_beats",     64'(beat_tid.size()), 64'd4);
        chk("t4_remaining", 64'(exp_q[1].size()), 64'd0);

        // Requester 2 stalls after its first beat; watchdog releases the grant.
        add_pkt(2, 3, 32'h5000);
        add_pkt(0, 1, 32'h6000);
        #1;
        tick();
        chk("t5_grant_c1", 64'(o_grant), 64'b100);
        tick();
        hold[2] = 1'b1;
        update_drive();
        #1;
        for (int k = 0; k < HT - 1; k++) begin
            tick();
            chk("t5_no_timeout_yet", 64'(hold_to), 64'd0);
            chk("t5_grant_kept",     64'(o_grant), 64'b100);
        end
        tick();
        chk("t5_timeout_set",  64'(hold_to), 64'd1);
        chk("t5_grant_clear",  64'(o_grant), 64'd0);
        src_q[2].delete(); exp_q[2].delete();
        cur_src = -1;
        hold[2] = 1'b0;
        update_drive();
        #1;
        tick();
        chk("t5_next_grant", 64'(o_grant), 64'b001);
        for (int k = 0; k < 20 && exp_q[0].size() > 0; k++) tick();
        chk("t5_next_served",  64'(exp_q[0].size()), 64'd0);
        chk("t5_timeout_sticky", 64'(hold_to), 64'd1);

        // Reset pulsed mid-packet.
        add_pkt(1, 4, 32'h7000);
        #1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_tvalid",  64'(nb_tvalid), 64'd0);
        chk("t6_grant",   64'(o_grant), 64'd0);
        chk("t6_tready",  64'(req_tready), 64'd0);
        chk("t6_timeout", 64'(hold_to), 64'd0);
        rst = 1'b0;
        flush_model();
        pkt_order.delete();
        for (int s = 0; s < N; s++) add_pkt(s, 1, DW'(32'h8000 + s));
        #1;
        for (int k = 0; k < 20 && pkt_order.size() < 3; k++) tick();
        chk("t6_pkt_count", 64'(pkt_order.size()), 64'd3);
        for (int p = 0; p < pkt_order.size(); p++)
            chk($sformatf("t6_order%0d", p), 64'(pkt_order[p]), 64'(p));

        // Randomized traffic, gaps and backpressure.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    add_pkt(i, int'($urandom_range(1, 4)), DW'($urandom));
                hold[i] = (hold_cnt[i] < 3) && ($urandom_range(0, 3) == 0);
            end
            nb_tready = ($urandom_range(0, 3) != 0);
            update_drive();
            #1;
            tick();
        end
        hold = '0;
        nb_tready = 1'b1;
        update_drive();
        #1;
        for (int k = 0; k < 200 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0; k++) tick();
        for (int i = 0; i < N; i++)
            chk($sformatf("rnd_drained%0d", i), 64'(exp_q[i].size()), 64'd0);
        chk("rnd_pkt_closed", 64'(cur_src + 1), 64'd0);
        chk("rnd_no_timeout", 64'(hold_to), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
